cdc_2phase_src_clearable: RTL and testbench

Source half of the two-phase (toggle req/ack) clock domain crossing, located in the transmitting clock domain. It accepts one data item at a time through a valid/ready handshake and flips `async_req_o` to announce it. It holds `async_data_o` stable until the synchronized `async_ack_i` matches the request. A synchronous clear returns the link to the idle phase (req = 0) in step with the destination half's clear.

---
 rtl/cdc_2phase_pkg.sv | 10 +
 rtl/sync.sv | 24 ++
 rtl/cdc_2phase_src_clearable.sv | 90 +++++++++
 tb/tb_cdc_2phase_src_clearable.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cdc_2phase_pkg.sv
// Shared types for the clearable two-phase CDC halves (source and destination).
package cdc_2phase_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        CLEARING = 2'd2
    } cdc_state_e;

endpackage

// File: rtl/sync.sv
// Multi-stage flip-flop synchronizer for a single asynchronous bit.
module sync #(
    parameter int unsigned STAGES      = 2,
    parameter bit          RESET_VALUE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic serial_i,
    output logic serial_o
);

    logic [STAGES-1:0] reg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_q <= {STAGES{RESET_VALUE}};
        end else begin
            reg_q <= {reg_q[STAGES-2:0], serial_i};
        end
    end

    assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/cdc_2phase_src_clearable.sv
// Source half of a toggle req/ack CDC link: one item in flight at a time,
// with a synchronous clear that parks the link in the req = 0 phase.
module cdc_2phase_src_clearable
    import cdc_2phase_pkg::*;
#(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             async_req_o,
    input  logic             async_ack_i,
    output logic [WIDTH-1:0] async_data_o
);

    cdc_state_e       state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ack_synced;
    logic             accept;

    sync #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (1'b0)
    ) i_ack_sync (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .serial_i (async_ack_i),
        .serial_o (ack_synced)
    );

    assign ready_o = (state_q == IDLE) && !clear_i;
    assign accept  = valid_i && ready_o;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        // Clear wins over everything; data is held so the destination never
        // sees a spurious change on the bus.
        if (clear_i) begin
            state_d = CLEARING;
            req_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = BUSY;
                        req_d   = ~req_q;
                        data_d  = data_i;
                    end
                end
                BUSY: begin
                    if (ack_synced == req_q) begin
                        state_d = IDLE;
                    end
                end
                CLEARING: begin
                    // Wait until the destination has also returned to phase 0.
                    if (!ack_synced) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

    assign async_req_o  = req_q;
    assign async_data_o = data_q;

endmodule

// File: tb/tb_cdc_2phase_src_clearable.sv
// Randomized bench for the clearable two-phase CDC source half against a
// transaction-level model plus a behavioural destination.
module tb_cdc_2phase_src_clearable;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         clear_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic         async_req_o;
    logic         async_ack_i = 1'b0;
    logic [W-1:0] async_data_o;

    int n_cmp = 0;
    int n_err = 0;

    cdc_2phase_src_clearable #(
        .WIDTH       (W),
        .SYNC_STAGES (S)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .async_req_o  (async_req_o),
        .async_ack_i  (async_ack_i),
        .async_data_o (async_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: link phase, held word, and what the source has seen of ack.
    bit           m_req;
    logic [W-1:0] m_data;
    bit           m_in_flight;
    bit           m_draining;
    bit           ack_hist[$];

    task automatic model_reset();
        m_req       = 1'b0;
        m_data      = '0;
        m_in_flight = 1'b0;
        m_draining  = 1'b0;
        ack_hist    = {};
        for (int i = 0; i < S; i++) ack_hist.push_back(1'b0);
    endtask

    // The source sees ack as it was sampled S-1 edges before the latest one.
    function automatic bit m_ack_seen();
        return ack_hist[ack_hist.size() - S];
    endfunction

    function automatic bit m_ready(input bit clr);
        return !m_in_flight && !m_draining && !clr;
    endfunction

    // One source cycle: drive at negedge, advance the model at the posedge.
    task automatic cycle(input bit v, input logic [W-1:0] d, input bit c, input bit a,
                         output bit accepted);
        bit seen;
        @(negedge clk_i);
        valid_i     = v;
        data_i      = d;
        clear_i     = c;
        async_ack_i = a;
        #1;
        check("ready", {31'd0, ready_o}, {31'd0, m_ready(c)});
        @(posedge clk_i);
        seen     = m_ack_seen();
        accepted = v && m_ready(c);
        if (c) begin
            m_draining  = 1'b1;
            m_in_flight = 1'b0;
            m_req       = 1'b0;
        end else if (accepted) begin
            m_in_flight = 1'b1;
            m_req       = !m_req;
            m_data      = d;
        end else if (m_in_flight && seen == m_req) begin
            m_in_flight = 1'b0;
        end else if (m_draining && !seen) begin
            m_draining = 1'b0;
        end
        ack_hist.push_back(a);
        if (ack_hist.size() > S) void'(ack_hist.pop_front());
        #1;
        check("req", {31'd0, async_req_o}, {31'd0, m_req});
        check("data", {24'd0, async_data_o}, {24'd0, m_data});
    endtask

    initial begin
        bit           acc;
        int           idx;
        int           cyc;
        int           dst_wait;
        int           toggles;
        bit           dst_ack;
        bit           prev_req;
        bit           v;
        logic [W-1:0] d;
        logic [W-1:0] rx[$];

        // Reset
        model_reset();
        #3;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_req", {31'd0, async_req_o}, 32'd0);
        check("rst_data", {24'd0, async_data_o}, 32'h00);
        @(negedge clk_i);
        rst_ni = 1'b1;
        $display("reset released");

        // Single transfer of 8'hA5, ack returned after two idle cycles
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, acc);
        check("single_acc_req", {31'd0, async_req_o}, 32'd1);
        check("single_acc_data", {24'd0, async_data_o}, 32'hA5);
        $display("single: accepted=%0d req=%0d data=%02h", acc, async_req_o, async_data_o);
        cycle(1'b0, 8'h11, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h22, 1'b0, 1'b0, acc);
        cycle(1'b0, 8'h33, 1'b0, 1'b1, acc);
        cycle(1'b0, 8'h44, 1'b0, 1'b1, acc);
        check("single_ready_edge2", {31'd0, ready_o}, 32'd0);
        cycle(1'b0, 8'h55, 1'b0, 1'b1, acc);
        check("single_ready_edge3", {31'd0, ready_o}, 32'd1);
        check("single_data_hold", {24'd0, async_data_o}, 32'hA5);
        $display("single: ready back after ack, data=%02h", async_data_o);

        // Clear with a stale ack still high
        cycle(1'b0, 8'h66, 1'b1, 1'b1, acc);
        check("stale_req_low", {31'd0, async_req_o}, 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1, acc);
        check("stale_ready_held", {31'd0, ready_o}, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'($urandom), 1'b0, 1'b0, acc);
        check("stale_ready_back", {31'd0, ready_o}, 32'd1);
        $display("stale-ack clear: ready=%0d", ready_o);

        // Clear while busy, ack held low
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
        check("busy_clear_req", {31'd0, async_req_o}, 32'd0);
        check("busy_clear_data", {24'd0, async_data_o}, 32'h3C);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
        check("busy_clear_ready", {31'd0, ready_o}, 32'd1);
        $display("busy clear: req=%0d data=%02h", async_req_o, async_data_o);

        // valid and clear in the same cycle
        cycle(1'b1, 8'h77, 1'b1, 1'b0, acc);
        check("vc_accepted", {31'd0, acc}, 32'd0);
        check("vc_data", {24'd0, async_data_o}, 32'h3C);
        check("vc_req", {31'd0, async_req_o}, 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
        $display("valid+clear: data=%02h req=%0d", async_data_o, async_req_o);

        // Back-to-back stream against a behavioural destination with random latency
        idx      = 0;
        cyc      = 0;
        dst_ack  = 1'b0;
        dst_wait = $urandom_range(0, 4);
        toggles  = 0;
        prev_req = async_req_o;
        while ((rx.size() < 100) && (cyc < 6000)) begin
            if (async_req_o != dst_ack) begin
                if (dst_wait == 0) begin
                    rx.push_back(async_data_o);
                    $display("rx #%0d: %0d", rx.size() - 1, async_data_o);
                    dst_ack  = !dst_ack;
                    dst_wait = $urandom_range(0, 4);
                end else begin
                    dst_wait--;
                end
            end
            v = (idx < 100) && ($urandom_range(0, 3) != 0);
            d = v ? 8'(idx) : 8'($urandom);
            cycle(v, d, 1'b0, dst_ack, acc);
            if (acc) idx++;
            if (async_req_o != prev_req) toggles++;
            prev_req = async_req_o;
            cyc++;
        end
        check("b2b_count", rx.size(), 32'd100);
        for (int i = 0; i < rx.size() && i < 100; i++) begin
            check($sformatf("b2b_item%0d", i), {24'd0, rx[i]}, i);
        end
        check("b2b_toggles", toggles, 32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
